// File: rtl/mmio_fifo_pkg.sv
// Shared constants and the STATUS register layout for the MMIO FIFO bank.
// The struct field order matches the 64-bit STATUS word from MSB to LSB.
package mmio_fifo_pkg;

  localparam int unsigned DATA_OFS   = 0;
  localparam int unsigned STATUS_OFS = 2;
  localparam int unsigned CH_STRIDE  = 4;

  localparam int unsigned FLUSH_BIT  = 0;
  localparam int unsigned CLR_BIT    = 1;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [15:0] depth;
    logic [11:0] rsvd_mid;
    logic        unf;
    logic        ovf;
    logic        full;
    logic        empty;
    logic [15:0] count;
  } t_fifo_status;

endpackage

// File: rtl/mmio_fifo_chan.sv
// One circular FIFO channel: DEPTH x DATA_W storage, pointers, count and sticky flags.
// rdata is the combinational head (zero when empty) so the top can register it with the pop.
module mmio_fifo_chan
  import mmio_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              clr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output t_fifo_status      status,
  output logic              not_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              not_empty_q, not_empty_d;

  logic empty, full, pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push && full && !pop) ovf_d = 1'b1;
    if (pop && empty)         unf_d = 1'b1;

    if (clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    // Flush overrides any pointer movement from this cycle; the popped head was already read.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    not_empty_d = (count_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      not_empty_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      not_empty_q <= not_empty_d;
    end
  end

  // NOTE: storage is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_comb begin
    status       = '0;
    status.count = 16'(count_q);
    status.empty = empty;
    status.full  = full;
    status.ovf   = ovf_q;
    status.unf   = unf_q;
    status.depth = 16'(DEPTH);
  end

  assign not_empty = not_empty_q;

endmodule

// File: rtl/mmio_fifo_bank.sv
// Bank of NUM_CH MMIO-mapped FIFOs: address decode, per-channel strobes,
// 64-bit read mux and a one-cycle registered read response.
module mmio_fifo_bank
  import mmio_fifo_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 64,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mmio_wr_valid,
  input  logic              mmio_rd_valid,
  input  logic [15:0]       mmio_addr,
  input  logic [8:0]        mmio_tid,
  input  logic [63:0]       mmio_wr_data,
  output logic              rd_rsp_valid,
  output logic              rd_rsp_hit,
  output logic [8:0]        rd_rsp_tid,
  output logic [63:0]       rd_rsp_data,
  output logic [NUM_CH-1:0] ch_not_empty
);

  logic [15:0]       offset;
  logic [3:0]        ch_idx;
  logic              in_range, is_data, is_status;
  logic [NUM_CH-1:0] push, pop, flush, clr;
  logic [63:0]       rd_word;

  logic [DATA_W-1:0] ch_rdata  [NUM_CH];
  t_fifo_status      ch_status [NUM_CH];

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_hit_q,   rsp_hit_d;
  logic [8:0]  rsp_tid_q,   rsp_tid_d;
  logic [63:0] rsp_data_q,  rsp_data_d;

  always_comb begin
    offset    = mmio_addr - BASE_ADDR;
    // Channel stride is 4 words, so the channel index sits directly above the register offset.
    ch_idx    = offset[5:2];
    in_range  = (mmio_addr >= BASE_ADDR) && (offset < 16'(NUM_CH * CH_STRIDE));
    is_data   = in_range && (offset[1:0] == 2'(DATA_OFS));
    is_status = in_range && (offset[1:0] == 2'(STATUS_OFS));

    push    = '0;
    pop     = '0;
    flush   = '0;
    clr     = '0;
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == 4'(c)) begin
        push[c]  = mmio_wr_valid && is_data;
        pop[c]   = mmio_rd_valid && is_data;
        flush[c] = mmio_wr_valid && is_status && mmio_wr_data[FLUSH_BIT];
        clr[c]   = mmio_wr_valid && is_status && mmio_wr_data[CLR_BIT];
        if (is_data)        rd_word[DATA_W-1:0] = ch_rdata[c];
        else if (is_status) rd_word             = ch_status[c];
      end
    end

    rsp_valid_d = mmio_rd_valid;
    rsp_hit_d   = mmio_rd_valid && (is_data || is_status);
    rsp_tid_d   = mmio_rd_valid ? mmio_tid : rsp_tid_q;
    rsp_data_d  = rsp_hit_d ? rd_word : '0;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mmio_fifo_chan #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .push      (push[c]),
      .pop       (pop[c]),
      .flush     (flush[c]),
      .clr       (clr[c]),
      .wdata     (mmio_wr_data[DATA_W-1:0]),
      .rdata     (ch_rdata[c]),
      .status    (ch_status[c]),
      .not_empty (ch_not_empty[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_hit   = rsp_hit_q;
  assign rd_rsp_tid   = rsp_tid_q;
  assign rd_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Self-checking bench for mmio_fifo_bank: directed scenarios followed by random traffic,
// all compared against a queue-based model of the channel FIFOs.
module tb_mmio_fifo_bank;

  localparam int          NUM_CH = 4;
  localparam int          DEPTH  = 8;
  localparam int          DATA_W = 64;
  localparam logic [15:0] BASE   = 16'h0020;

  logic              clk = 1'b0;
  logic              rst;
  logic              mmio_wr_valid, mmio_rd_valid;
  logic [15:0]       mmio_addr;
  logic [8:0]        mmio_tid;
  logic [63:0]       mmio_wr_data;
  logic              rd_rsp_valid, rd_rsp_hit;
  logic [8:0]        rd_rsp_tid;
  logic [63:0]       rd_rsp_data;
  logic [NUM_CH-1:0] ch_not_empty;

  always #5 clk = ~clk;

  mmio_fifo_bank #(
    .NUM_CH    (NUM_CH),
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .BASE_ADDR (BASE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mmio_wr_valid (mmio_wr_valid),
    .mmio_rd_valid (mmio_rd_valid),
    .mmio_addr     (mmio_addr),
    .mmio_tid      (mmio_tid),
    .mmio_wr_data  (mmio_wr_data),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_hit    (rd_rsp_hit),
    .rd_rsp_tid    (rd_rsp_tid),
    .rd_rsp_data   (rd_rsp_data),
    .ch_not_empty  (ch_not_empty)
  );

  // Reference model: one queue per channel plus the two sticky flags.
  logic [63:0] mq [NUM_CH][$];
  bit          ovf_m [NUM_CH];
  bit          unf_m [NUM_CH];

  bit          exp_valid, exp_hit, exp_zero;
  logic [8:0]  exp_tid;
  logic [63:0] exp_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit decode(input logic [15:0] a, output int ch, output bit isd, output bit iss);
    int off;
    off = int'(a) - int'(BASE);
    ch  = 0;
    isd = 1'b0;
    iss = 1'b0;
    if (off < 0 || off >= NUM_CH * 4) return 1'b0;
    ch  = off / 4;
    isd = (off % 4) == 0;
    iss = (off % 4) == 2;
    return isd || iss;
  endfunction

  function automatic logic [63:0] status_word(input int ch);
    logic [63:0] w;
    int n;
    n = mq[ch].size();
    w = 64'(n);
    if (n == 0)     w = w + 64'h1_0000;
    if (n == DEPTH) w = w + 64'h2_0000;
    if (ovf_m[ch])  w = w + 64'h4_0000;
    if (unf_m[ch])  w = w + 64'h8_0000;
    w = w + (64'(DEPTH) << 32);
    return w;
  endfunction

  function automatic logic [NUM_CH-1:0] model_ne();
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = (mq[c].size() != 0);
    return v;
  endfunction

  // One bus cycle: check the response to the previous cycle, then drive and model this one.
  task automatic cycle(input bit rs, input bit wr, input bit rd, input logic [15:0] addr,
                       input logic [63:0] wd);
    int ch;
    bit isd, iss, mapped;
    int pre;
    logic [8:0] tid;
    @(negedge clk);
    check("rsp_valid", 64'(rd_rsp_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("rsp_hit", 64'(rd_rsp_hit), 64'(exp_hit));
      check("rsp_tid", 64'(rd_rsp_tid), 64'(exp_tid));
      check("rsp_data", rd_rsp_data, exp_data);
    end
    if (exp_zero) begin
      check("rst_hit", 64'(rd_rsp_hit), 64'd0);
      check("rst_tid", 64'(rd_rsp_tid), 64'd0);
      check("rst_data", rd_rsp_data, 64'd0);
    end
    check("not_empty", 64'(ch_not_empty), 64'(model_ne()));

    tid           = 9'($urandom);
    rst           = rs;
    mmio_wr_valid = wr;
    mmio_rd_valid = rd;
    mmio_addr     = addr;
    mmio_tid      = tid;
    mmio_wr_data  = wd;

    exp_valid = rd && !rs;
    exp_zero  = rs;
    exp_hit   = 1'b0;
    exp_tid   = tid;
    exp_data  = '0;
    if (rs) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mq[c].delete();
        ovf_m[c] = 1'b0;
        unf_m[c] = 1'b0;
      end
    end else begin
      mapped = decode(addr, ch, isd, iss);
      if (mapped && rd) begin
        exp_hit = 1'b1;
        if (iss) exp_data = status_word(ch);
      end
      if (mapped && isd) begin
        pre = mq[ch].size();
        if (rd) begin
          if (pre == 0) unf_m[ch] = 1'b1;
          else          exp_data = mq[ch].pop_front();
        end
        if (wr) begin
          if (pre < DEPTH || rd) mq[ch].push_back(wd);
          else                   ovf_m[ch] = 1'b1;
        end
      end
      if (mapped && iss && wr) begin
        if (wd[0]) mq[ch].delete();
        if (wd[1]) begin
          ovf_m[ch] = 1'b0;
          unf_m[ch] = 1'b0;
        end
      end
    end
  endtask

  task automatic wr_(input logic [15:0] a, input logic [63:0] d); cycle(0, 1, 0, a, d); endtask
  task automatic rd_(input logic [15:0] a);                       cycle(0, 0, 1, a, 64'd0); endtask
  task automatic idle();                                          cycle(0, 0, 0, 16'd0, 64'd0); endtask

  logic [15:0] ra;
  logic [63:0] rw;

  initial begin
    rst = 1'b1; mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
    mmio_addr = '0; mmio_tid = '0; mmio_wr_data = '0;
    exp_valid = 1'b0; exp_hit = 1'b0; exp_zero = 1'b1; exp_tid = '0; exp_data = '0;

    cycle(1, 0, 0, 16'd0, 64'd0);
    cycle(1, 0, 0, 16'd0, 64'd0);
    idle();

    // Reset STATUS of channel 0.
    rd_(16'h0022);
    idle();
    check("st0_reset_literal", status_word(0), 64'h0000_0008_0001_0000);

    // Fill ch1, overflow, read status, drain in order.
    for (int i = 0; i < 8; i++) wr_(16'h0024, 64'hA1 + 64'(i));
    wr_(16'h0024, 64'hA9);
    rd_(16'h0026);
    for (int i = 0; i < 8; i++) rd_(16'h0024);
    rd_(16'h0026);

    // Underflow on ch2, then clear sticky flags.
    rd_(16'h0028);
    rd_(16'h002A);
    wr_(16'h002A, 64'h2);
    rd_(16'h002A);
    wr_(16'h0026, 64'h2);
    rd_(16'h0026);

    // Full ch0 with simultaneous push+pop, then wrap the pointers.
    for (int i = 0; i < 8; i++) wr_(16'h0020, 64'hC000 + 64'(i));
    cycle(0, 1, 1, 16'h0020, 64'hC0FF);
    rd_(16'h0022);
    for (int i = 0; i < 12; i++) begin
      rd_(16'h0020);
      wr_(16'h0020, 64'hD000 + 64'(i));
    end
    for (int i = 0; i < 8; i++) rd_(16'h0020);
    rd_(16'h0022);

    // Empty ch2 with push+pop: returns 0, sets unf, count becomes 1.
    cycle(0, 1, 1, 16'h0028, 64'h5555);
    rd_(16'h002A);
    rd_(16'h0028);

    // Flush ch3, unmapped read.
    for (int i = 0; i < 3; i++) wr_(16'h002C, 64'hE0 + 64'(i));
    wr_(16'h002E, 64'h1);
    idle();
    rd_(16'h002E);
    rd_(16'h0060);
    rd_(16'h0021);
    rd_(16'h001C);

    // Reset mid-burst with a read outstanding.
    for (int i = 0; i < 3; i++) wr_(16'h0020, 64'hF0 + 64'(i));
    wr_(16'h0024, 64'hF8);
    rd_(16'h0020);
    rd_(16'h0020);
    cycle(1, 0, 1, 16'h0020, 64'd0);
    idle();
    for (int c = 0; c < NUM_CH; c++) rd_(BASE + 16'(4 * c + 2));

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0:       ra = 16'($urandom);
        1, 2, 3: ra = BASE + 16'(4 * $urandom_range(0, NUM_CH - 1) + 2);
        default: ra = BASE + 16'(4 * $urandom_range(0, NUM_CH - 1));
      endcase
      rw = {$urandom, $urandom};
      if (ra[1:0] == 2'b10 && $urandom_range(0, 9) != 0) rw[0] = 1'b0;
      cycle(0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, ra, rw);
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
